conv_psum_accum: RTL and testbench

- Downstream stage of the crossbar conv block. It consumes the per-cycle ADC_P-bit crossbar column result.
- Input activations are streamed bit-serially, LSB first, so each ADC sample carries the weight 2^bit.
- The block shift-accumulates IN_BITS bit-planes across N_TILES crossbar tiles into one output-channel partial sum.
- It presents the completed sum on a valid/ready interface to the next stage (pooling/requant).

---
 rtl/conv_pkg.sv | 37 +++
 rtl/psum_out_reg.sv | 64 ++++++
 rtl/conv_psum_accum.sv | 90 +++++++++
 tb/tb_conv_psum_accum.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and width helpers for the crossbar conv pipeline.
// Holds the default ADC/activation/tile geometry used by the crossbar stage,
// the address sequencer and the partial-sum accumulator.
package conv_pkg;

    // Default geometry shared across the conv block stages.
    localparam int CONV_ADC_P   = 8;
    localparam int CONV_IN_BITS = 8;
    localparam int CONV_N_TILES = 4;

    // Output holding register state: ACCUM = no result held, PENDING = result held.
    typedef enum logic {
        ACCUM   = 1'b0,
        PENDING = 1'b1
    } psum_state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Index width for a counter over 'count' values, never narrower than one bit.
    function automatic int idx_width(input int count);
        return (clog2(count) < 1) ? 1 : clog2(count);
    endfunction

    // Minimum accumulator width that holds N_TILES*(2^ADC_P-1)*(2^IN_BITS-1).
    function automatic int acc_width(input int adc_p, input int in_bits, input int n_tiles);
        return adc_p + in_bits + clog2(n_tiles);
    endfunction

endpackage

// File: rtl/psum_out_reg.sv
// One-entry valid/ready holding register for completed partial sums.
// Latency: a load is visible on out_valid/out_data the cycle after the loading edge.
// Backpressure: can_load drops while a result is held and out_ready is low; drain and load
// on the same edge keep out_valid high with the new data (no bubble).
// Ports: clk, rst (async active-low), load/load_data (new result), out_valid/out_ready/out_data
// (downstream handshake), can_load (upstream may produce a result this cycle).
module psum_out_reg
    import conv_pkg::*;
#(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         can_load
);

    psum_state_t state;
    psum_state_t state_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: begin
                if (load) begin
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                // A load here implies out_ready, so the old result drains as the new one lands.
                if (load) begin
                    state_nxt = PENDING;
                end else if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data <= '0;
        end else if (load) begin
            out_data <= load_data;
        end
    end

    assign out_valid = (state == PENDING);
    assign can_load  = !(out_valid && !out_ready);

endmodule

// File: rtl/conv_psum_accum.sv
// Shift-accumulates bit-serial (LSB-first) crossbar ADC samples over IN_BITS planes and N_TILES tiles.
// Latency: out_valid rises on the edge accepting the final sample of a sum.
// Backpressure: in_ready = !(out_valid && !out_ready); accumulation stalls while a result is held.
// Ports: clk, rst (async active-low), clr (sync abort), in_valid/in_ready/in_data (ADC samples),
// out_valid/out_ready/out_data (completed sum), bit_idx/tile_idx (next expected plane/tile).
module conv_psum_accum
    import conv_pkg::*;
#(
    parameter int ADC_P   = CONV_ADC_P,
    parameter int IN_BITS = CONV_IN_BITS,
    parameter int N_TILES = CONV_N_TILES,
    parameter int ACC_W   = acc_width(CONV_ADC_P, CONV_IN_BITS, CONV_N_TILES),
    localparam int BW     = idx_width(IN_BITS),
    localparam int TW     = idx_width(N_TILES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ADC_P-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [BW-1:0]    bit_idx,
    output logic [TW-1:0]    tile_idx
);

    localparam logic [BW-1:0] BIT_LAST  = BW'(IN_BITS - 1);
    localparam logic [TW-1:0] TILE_LAST = TW'(N_TILES - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] sum;
    logic [BW-1:0]    bit_cnt;
    logic [TW-1:0]    tile_cnt;
    logic             bit_last;
    logic             tile_last;
    logic             accept;
    logic             final_load;

    // With IN_BITS=1 or N_TILES=1 the counter stays at 0 and equals its LAST constant.
    assign bit_last  = (bit_cnt == BIT_LAST);
    assign tile_last = (tile_cnt == TILE_LAST);

    assign accept     = in_valid && in_ready && !clr;
    assign final_load = accept && bit_last && tile_last;

    // Each bit-plane sample carries weight 2^bit_cnt.
    assign addend = {{(ACC_W - ADC_P){1'b0}}, in_data} << bit_cnt;
    assign sum    = acc + addend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            bit_cnt  <= '0;
            tile_cnt <= '0;
        end else if (clr) begin
            acc      <= '0;
            bit_cnt  <= '0;
            tile_cnt <= '0;
        end else if (accept) begin
            // The finished sum leaves through the output register; restart from zero.
            acc <= final_load ? '0 : sum;
            if (bit_last) begin
                bit_cnt  <= '0;
                tile_cnt <= tile_last ? '0 : tile_cnt + TW'(1);
            end else begin
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

    psum_out_reg #(
        .W(ACC_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (final_load),
        .load_data (sum),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .can_load  (in_ready)
    );

    assign bit_idx  = bit_cnt;
    assign tile_idx = tile_cnt;

endmodule

// File: tb/tb_conv_psum_accum.sv
// Directed bench for conv_psum_accum: default geometry instance plus a degenerate
// single-sample instance (IN_BITS=1, N_TILES=1) used for the back-to-back drain+load case.
// Expected values are hand-computed constants.
module tb_conv_psum_accum;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
    logic [2:0]  bit_idx;
    logic [1:0]  tile_idx;

    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  in_data2;
    logic        out_valid2;
    logic        out_ready2;
    logic [8:0]  out_data2;
    logic [0:0]  bit_idx2;
    logic [0:0]  tile_idx2;

    int compared;
    int mismatched;

    conv_psum_accum #(
        .ADC_P(8), .IN_BITS(8), .N_TILES(4), .ACC_W(18)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .bit_idx(bit_idx), .tile_idx(tile_idx)
    );

    conv_psum_accum #(
        .ADC_P(8), .IN_BITS(1), .N_TILES(1), .ACC_W(9)
    ) dut2 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .bit_idx(bit_idx2), .tile_idx(tile_idx2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'd0;
    endtask

    task automatic feed2(input logic [7:0] d);
        in_valid2 = 1'b1;
        in_data2  = d;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        in_data2  = 8'd0;
    endtask

    task automatic feed_n(input int n, input logic [7:0] d);
        for (int i = 0; i < n; i++) begin
            feed(d);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        clr        = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        out_ready  = 1'b1;
        in_valid2  = 1'b0;
        in_data2   = 8'd0;
        out_ready2 = 1'b1;

        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_bit_idx", 32'(bit_idx), 32'd0);
        chk("rst_tile_idx", 32'(tile_idx), 32'd0);
        idle();
        rst = 1'b1;

        // All ones: 4 tiles * 255 = 1020
        feed_n(31, 8'd1);
        chk("ones_pre_valid", 32'(out_valid), 32'd0);
        chk("ones_pre_bit", 32'(bit_idx), 32'd7);
        chk("ones_pre_tile", 32'(tile_idx), 32'd3);
        feed(8'd1);
        chk("ones_valid", 32'(out_valid), 32'd1);
        chk("ones_data", 32'(out_data), 32'd1020);
        chk("ones_bit_wrap", 32'(bit_idx), 32'd0);
        chk("ones_tile_wrap", 32'(tile_idx), 32'd0);
        idle();
        chk("ones_pulse_end", 32'(out_valid), 32'd0);

        // Full scale: 4 * 255 * 255 = 260100
        feed_n(32, 8'd255);
        chk("max_valid", 32'(out_valid), 32'd1);
        chk("max_data", 32'(out_data), 32'd260100);
        idle();

        // Single nonzero sample: 3 << 7 at tile 2 = 384
        for (int t = 0; t < 4; t++) begin
            for (int b = 0; b < 8; b++) begin
                feed((t == 2 && b == 7) ? 8'd3 : 8'd0);
            end
        end
        chk("single_data", 32'(out_data), 32'd384);
        idle();

        // Stall with out_ready low; input samples must be ignored
        feed_n(31, 8'd1);
        out_ready = 1'b0;
        feed(8'd1);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'd255;
            idle();
            chk("stall_hold_data", 32'(out_data), 32'd1020);
            chk("stall_hold_ready", 32'(in_ready), 32'd0);
            chk("stall_hold_bit", 32'(bit_idx), 32'd0);
        end
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        #1;
        chk("stall_release_ready", 32'(in_ready), 32'd1);
        idle();
        chk("stall_drained", 32'(out_valid), 32'd0);
        chk("stall_no_sample", 32'(bit_idx), 32'd0);

        // clr discards residue and same-cycle sample
        feed_n(13, 8'd1);
        chk("clr_pre_bit", 32'(bit_idx), 32'd5);
        chk("clr_pre_tile", 32'(tile_idx), 32'd1);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd255;
        idle();
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        chk("clr_bit", 32'(bit_idx), 32'd0);
        chk("clr_tile", 32'(tile_idx), 32'd0);
        feed_n(32, 8'd1);
        chk("clr_data", 32'(out_data), 32'd1020);
        idle();

        // Degenerate instance: every sample is final; drain and load on the same edge
        feed2(8'd5);
        chk("b2b_first_valid", 32'(out_valid2), 32'd1);
        chk("b2b_first_data", 32'(out_data2), 32'd5);
        feed2(8'd7);
        chk("b2b_second_valid", 32'(out_valid2), 32'd1);
        chk("b2b_second_data", 32'(out_data2), 32'd7);
        out_ready2 = 1'b0;
        #1;
        chk("b2b_stall_ready", 32'(in_ready2), 32'd0);
        in_valid2 = 1'b1;
        in_data2  = 8'd9;
        idle();
        in_valid2 = 1'b0;
        chk("b2b_stall_data", 32'(out_data2), 32'd7);
        out_ready2 = 1'b1;
        idle();
        chk("b2b_drained", 32'(out_valid2), 32'd0);

        // Async reset mid-tile
        feed_n(5, 8'd1);
        chk("arst_pre_bit", 32'(bit_idx), 32'd5);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_bit", 32'(bit_idx), 32'd0);
        chk("arst_tile", 32'(tile_idx), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;

        // Async reset while stalled with a pending result
        feed_n(31, 8'd1);
        out_ready = 1'b0;
        feed(8'd1);
        chk("arst_pend_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_pend_out_valid", 32'(out_valid), 32'd0);
        chk("arst_pend_out_data", 32'(out_data), 32'd0);
        chk("arst_pend_in_ready", 32'(in_ready), 32'd1);
        rst       = 1'b1;
        out_ready = 1'b1;
        feed_n(32, 8'd1);
        chk("arst_after_data", 32'(out_data), 32'd1020);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
